lsu: RTL and testbench

Load/store unit sitting directly downstream of the ALU in the single-cycle CPU. It takes the ALU result as the effective address, with the low two bits as the byte offset. It performs byte/half/word access to a variable-latency data memory over a req/ack handshake and returns an aligned, sign- or zero-extended load result. While an access is outstanding it holds the CPU with a stall signal, and it flags misaligned or timed-out accesses.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_lane.sv | 56 +++++
 rtl/lsu.sv | 153 +++++++++++++++
 tb/tb_lsu.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: definitions shared by the load/store unit.
//   - access size encodings carried on ls_size
//   - FSM state enum used by lsu
//   - cnt_width(): wait counter width, wide enough to hold TIMEOUT
package lsu_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;
    localparam logic [1:0] LS_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } lsu_state_e;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane logic for the load/store unit.
//   size, off, unsigned_ld : access size, byte offset, zero-extend select
//   wdata                  : raw store data (rt)
//   rdata                  : raw word returned by memory
//   misaligned             : access cannot be issued (bad offset or size 11)
//   be, wdata_rep          : byte enables and lane-replicated store data
//   rdata_fmt              : extracted, sign/zero-extended load result
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        unsigned_ld,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_fmt
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign misaligned = (size == LS_ILL)
                      || (size == LS_HALF && off[0])
                      || (size == LS_WORD && off != 2'b00);

    assign byte_v = rdata[8*off +: 8];
    assign half_v = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0;
        rdata_fmt = 32'h0;
        case (size)
            LS_BYTE: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_fmt = unsigned_ld ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            LS_HALF: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_fmt = unsigned_ld ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            end
            LS_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_fmt = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the ALU and a variable-latency data memory.
//   clk, rstn                  : clock, async active-low reset
//   ls_valid/we/size/unsigned/addr/wdata : CPU access request (held until done/err)
//   ls_stall, ls_done, ls_err, ls_rdata  : CPU-side status and load result
//   mem_req/we/addr/be/wdata   : registered memory request, stable while waiting
//   mem_ack, mem_rdata         : memory completion and read data
//
// state | meaning
// IDLE  | no access; accept ls_valid, check alignment
// WAIT  | mem_req high, waiting for mem_ack or timeout
// RESP  | ls_done pulse, formatted load data on ls_rdata
// ERR   | ls_err pulse (misaligned, illegal size or timeout)
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ls_valid,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_stall,
    output logic        ls_done,
    output logic        ls_err,
    output logic [31:0] ls_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q, uns_q;
    logic [1:0]       size_q, off_q;
    logic [31:0]      rdata_q;

    logic             start, ack_hit, tmo;
    logic [1:0]       sel_size, sel_off;
    logic             sel_uns;
    logic             lane_mis;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata, lane_rdata;

    // In IDLE the lane logic looks at the live request; afterwards at the latched copy.
    assign sel_size = (state_q == ST_IDLE) ? ls_size       : size_q;
    assign sel_off  = (state_q == ST_IDLE) ? ls_addr[1:0]  : off_q;
    assign sel_uns  = (state_q == ST_IDLE) ? ls_unsigned   : uns_q;

    lsu_lane u_lane (
        .size        (sel_size),
        .off         (sel_off),
        .unsigned_ld (sel_uns),
        .wdata       (ls_wdata),
        .rdata       (mem_rdata),
        .misaligned  (lane_mis),
        .be          (lane_be),
        .wdata_rep   (lane_wdata),
        .rdata_fmt   (lane_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        ack_hit = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ls_valid) begin
                    if (lane_mis) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_WAIT;
                        start   = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem_ack) begin
                    state_d = ST_RESP;
                    ack_hit = 1'b1;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
                    state_d = ST_ERR;
                    tmo     = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ls_done  = (state_q == ST_RESP);
    assign ls_err   = (state_q == ST_ERR);
    assign ls_rdata = (ls_done && !we_q) ? rdata_q : 32'h0;
    assign ls_stall = ls_valid & ~ls_done & ~ls_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= LS_BYTE;
            off_q     <= 2'b00;
            rdata_q   <= 32'h0;
        end else if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= {ls_addr[31:2], 2'b00};
            mem_be    <= lane_be;
            mem_wdata <= lane_wdata;
            cnt_q     <= '0;
            we_q      <= ls_we;
            uns_q     <= ls_unsigned;
            size_q    <= ls_size;
            off_q     <= ls_addr[1:0];
        end else if (state_q == ST_WAIT) begin
            if (ack_hit || tmo) begin
                // Return the bus to idle so nothing lingers after the access.
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= 32'h0;
                mem_be    <= 4'h0;
                mem_wdata <= 32'h0;
                cnt_q     <= '0;
                if (ack_hit) rdata_q <= lane_rdata;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ls_valid, ls_we, ls_unsigned;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_stall, ls_done, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .ls_valid(ls_valid), .ls_we(ls_we), .ls_size(ls_size),
        .ls_unsigned(ls_unsigned), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_stall(ls_stall), .ls_done(ls_done), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: byte counts and arithmetic, little-endian lanes.
    function automatic int nbytes(input int size);
        return (size == 0) ? 1 : (size == 1) ? 2 : 4;
    endfunction

    function automatic bit m_mis(input int size, input int off);
        return (size == 3) || (size == 1 && (off % 2) != 0) || (size == 2 && off != 0);
    endfunction

    function automatic logic [31:0] m_be(input int size, input int off);
        longint m;
        m = ((longint'(1) << nbytes(size)) - 1) << off;
        return 32'(m);
    endfunction

    function automatic logic [31:0] m_wdata(input int size, input logic [31:0] d);
        if (size == 0) return (d % 256) * 32'h01010101;
        if (size == 1) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int size, input int off, input bit uns,
                                           input logic [31:0] raw);
        longint v, bits;
        bits = 8 * nbytes(size);
        v = (longint'(raw) >> (8 * off)) % (longint'(1) << bits);
        if (!uns && bits < 32 && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    task automatic run(input string name, input bit we, input int size, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit uns, input logic [31:0] raw,
                       input int delay);
        int  off, endc, last_req;
        bit  mis, done_ok;
        off  = int'(addr[1:0]);
        mis  = m_mis(size, off);
        done_ok = !mis && (delay < TMO);
        endc = mis ? 1 : (done_ok ? delay + 2 : TMO + 1);
        last_req = mis ? 0 : (done_ok ? delay + 1 : TMO);
        @(posedge clk); #1;
        ls_valid = 1'b1; ls_we = we; ls_size = 2'(size); ls_unsigned = uns;
        ls_addr = addr; ls_wdata = wdata;
        for (int cyc = 0; cyc <= endc; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            mem_ack   = (cyc == delay + 1);
            mem_rdata = raw;
            @(negedge clk);
            check($sformatf("%s.stall c%0d", name, cyc), 32'(ls_stall), 32'(cyc < endc));
            check($sformatf("%s.req c%0d", name, cyc), 32'(mem_req),
                  32'(cyc >= 1 && cyc <= last_req));
            check($sformatf("%s.done c%0d", name, cyc), 32'(ls_done), 32'(cyc == endc && done_ok));
            check($sformatf("%s.err c%0d", name, cyc), 32'(ls_err), 32'(cyc == endc && !done_ok));
            check($sformatf("%s.rdata c%0d", name, cyc), ls_rdata,
                  (cyc == endc && done_ok && !we) ? m_load(size, off, uns, raw) : 32'h0);
            if (cyc >= 1 && cyc <= last_req) begin
                check($sformatf("%s.addr c%0d", name, cyc), mem_addr, addr & 32'hFFFF_FFFC);
                check($sformatf("%s.be c%0d", name, cyc), 32'(mem_be), m_be(size, off));
                check($sformatf("%s.we c%0d", name, cyc), 32'(mem_we), 32'(we));
                if (we) check($sformatf("%s.wdata c%0d", name, cyc), mem_wdata, m_wdata(size, wdata));
            end
        end
        @(posedge clk); #1;
        ls_valid = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".stall"}, 32'(ls_stall), 32'h0);
        check({name, ".done"}, 32'(ls_done), 32'h0);
        check({name, ".err"}, 32'(ls_err), 32'h0);
        check({name, ".rdata"}, ls_rdata, 32'h0);
        check({name, ".req"}, 32'(mem_req), 32'h0);
        check({name, ".we"}, 32'(mem_we), 32'h0);
        check({name, ".addr"}, mem_addr, 32'h0);
        check({name, ".be"}, 32'(mem_be), 32'h0);
        check({name, ".wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        rstn = 1'b0; ls_valid = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_unsigned = 1'b0;
        ls_addr = 32'h0; ls_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1; rstn = 1'b1;

        run("sw",      1'b1, 2, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0, 0);
        run("sb",      1'b1, 0, 32'h0000_0103, 32'h0000_00A5, 1'b0, 32'h0, 1);
        run("sh_hi",   1'b1, 1, 32'h0000_0202, 32'h1234_5678, 1'b0, 32'h0, 2);
        run("lb3",     1'b0, 0, 32'h0000_0103, 32'h0, 1'b0, 32'h80FF_7F01, 0);
        run("lbu3",    1'b0, 0, 32'h0000_0103, 32'h0, 1'b1, 32'h80FF_7F01, 1);
        run("lb0",     1'b0, 0, 32'h0000_0100, 32'h0, 1'b0, 32'h80FF_7F01, 0);
        run("lh2",     1'b0, 1, 32'h0000_0102, 32'h0, 1'b0, 32'h80FF_7F01, 0);
        run("lhu0",    1'b0, 1, 32'h0000_0100, 32'h0, 1'b1, 32'h80FF_7F01, 2);
        run("lw",      1'b0, 2, 32'h0000_0100, 32'h0, 1'b1, 32'h80FF_7F01, 1);
        run("lw_mis",  1'b0, 2, 32'h0000_0102, 32'h0, 1'b0, 32'h0, 0);
        run("lh_mis",  1'b0, 1, 32'h0000_0101, 32'h0, 1'b0, 32'h0, 0);
        run("size11",  1'b1, 3, 32'h0000_0100, 32'h0, 1'b0, 32'h0, 0);
        run("tmo",     1'b1, 2, 32'h0000_0300, 32'hCAFE_F00D, 1'b0, 32'h0, 100);
        run("ack_4th", 1'b0, 2, 32'h0000_0300, 32'h0, 1'b0, 32'h1357_9BDF, TMO - 1);

        // Reset asserted mid-WAIT must clear everything without a done/err pulse.
        @(posedge clk); #1;
        ls_valid = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h0000_0400;
        ls_wdata = 32'hA5A5_5A5A; ls_unsigned = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst.req_before", 32'(mem_req), 32'h1);
        rstn = 1'b0; ls_valid = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk); #1; rstn = 1'b1;
        run("sw_after_rst", 1'b1, 2, 32'h0000_0400, 32'h0BAD_F00D, 1'b0, 32'h0, 0);

        for (int i = 0; i < 60; i++) begin
            run($sformatf("rnd%0d", i), 1'(($urandom % 2) != 0), int'($urandom_range(0, 3)),
                $urandom, $urandom, 1'(($urandom % 2) != 0), $urandom,
                int'($urandom_range(0, 5)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
